// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the parametrised UART receiver.
//   state_t    : receiver FSM states (3-bit encoding)
//   LINE_IDLE  : serial line level between frames / stop bit level
//   LINE_START : serial line level of a start bit
//   clog2()    : ceiling log2, used to size counters from parameters
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler -- line conditioning for the UART receiver.
// Synchronises the asynchronous serial input, captures the two samples
// before the decision tick and forms a 3-sample majority vote.
// Ports:
//   sys_clk, sys_rst_l : clock, asynchronous active-low reset
//   line               : raw asynchronous serial input
//   cnt                : bit-cell tick counter owned by the parent FSM
//   rxs                : synchronised line level
//   vote               : majority of rxs at ticks MID-1, MID and MID+1
//   decide             : high on tick MID+1, when vote is valid
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int CW         = clog2(OVERSAMPLE)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_l,
    input  logic          line,
    input  logic [CW-1:0] cnt,
    output logic          rxs,
    output logic          vote,
    output logic          decide
);

    localparam logic [CW-1:0] TICK_LO  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TICK_MID = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] TICK_DEC = CW'(OVERSAMPLE / 2 + 1);

    logic sync_p0;
    logic sync_p1;
    logic tap_lo;
    logic tap_mid;

    // Synchroniser flops reset to the idle level so no false start edge
    // appears on reset release.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            sync_p0 <= LINE_IDLE;
            sync_p1 <= LINE_IDLE;
        end else begin
            sync_p0 <= line;
            sync_p1 <= sync_p0;
        end
    end

    assign rxs = sync_p1;

    always_ff @(posedge sys_clk) begin
        if (cnt == TICK_LO)  tap_lo  <= rxs;
        if (cnt == TICK_MID) tap_mid <= rxs;
    end

    // Third sample is the live rxs on the decision tick itself.
    assign decide = (cnt == TICK_DEC);
    assign vote   = (tap_lo & tap_mid) | (tap_lo & rxs) | (tap_mid & rxs);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised oversampling UART receiver with a
// valid/ready holding register, framing and overrun detection.
// Optional parity checking is built when UART_RX_PARITY_EN is defined
// (adds parameter PARITY_ODD, 0 = even parity).
// Ports:
//   sys_clk, sys_rst_l : clock (OVERSAMPLE x baud), async active-low reset
//   uart_rx_i          : asynchronous serial line, idle high
//   rx_data_o          : received word, stable while rx_valid_o is high
//   rx_valid_o         : holding register full
//   rx_ready_i         : consumer accepts the word with rx_valid_o
//   frame_err_o        : 1-cycle pulse, a stop bit was sampled low
//   overrun_o          : 1-cycle pulse, a good word was dropped
//   parity_err_o       : 1-cycle pulse, parity mismatch (0 without parity)
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_l,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 parity_err_o
);

    localparam int CW = clog2(OVERSAMPLE);
    localparam int IW = clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] shreg;
    logic                 rxs;
    logic                 vote;
    logic                 decide;
`ifdef UART_RX_PARITY_EN
    logic                 par_acc;
    logic                 par_bad;
`endif

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CW         (CW)
    ) u_sampler (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .line      (uart_rx_i),
        .cnt       (cnt),
        .rxs       (rxs),
        .vote      (vote),
        .decide    (decide)
    );

    // Datapath: shift register fills MSB-first so bit 0 ends at the LSB.
    always_ff @(posedge sys_clk) begin
        if (state == DATA && decide) shreg <= {vote, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
        if (state == START)               par_acc <= PARITY_ODD;
        else if (state == DATA && decide) par_acc <= par_acc ^ vote;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            stop_bad     <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            cnt <= cnt + CW'(1);
            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (rxs == LINE_START) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                // The start cell runs to its end so data cells stay
                // aligned with the bit cells on the wire.
                START: begin
                    if (decide && vote == LINE_IDLE) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST_TICK) begin
                        state    <= DATA;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_bad  <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (cnt == LAST_TICK) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                            cnt <= '0;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide) par_bad <= (vote != par_acc);
                    if (cnt == LAST_TICK) begin
                        state <= STOP;
                        cnt   <= '0;
                    end
                end
`endif
                // Outcome is resolved on the final stop decision tick so a
                // new start edge can be caught right after.
                STOP: begin
                    if (decide && stop_idx == LAST_STOP) begin
                        cnt <= '0;
                        if (stop_bad || vote == LINE_START) begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end else begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err_o <= 1'b1;
                            end else
`endif
                            if (!rx_valid_o || rx_ready_i) begin
                                rx_data_o  <= shreg;
                                rx_valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end
                    end else if (decide) begin
                        if (vote == LINE_START) stop_bad <= 1'b1;
                    end else if (cnt == LAST_TICK) begin
                        stop_idx <= 1'b1;
                    end
                end
                // Needs a full cell of continuous idle level; any low
                // restarts the wait so a held-low line stays here.
                BREAK: begin
                    if (rxs == LINE_START) begin
                        cnt <= '0;
                    end else if (cnt == LAST_TICK) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- directed bench for uart_rx_param at 8 data bits,
// 16x oversampling, 1 stop bit. Parity steps are built only when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

    logic       sys_clk = 1'b0;
    logic       sys_rst_l;
    logic       uart_rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_LAT = 2 + 1 + 16 + 8 * 16 + 16 + 9 + 1;
`else
    localparam int FRAME_LAT = 2 + 1 + 16 + 8 * 16 + 9 + 1;
`endif

    uart_rx_param #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .STOP_BITS  (1)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_l    (sys_rst_l),
        .uart_rx_i    (uart_rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event counters sampled on the falling edge.
    int   vcnt = 0;
    int   fcnt = 0;
    int   ocnt = 0;
    int   pcnt = 0;
    int   rise_cyc = -1;
    logic prev_v = 1'b0;
    always @(negedge sys_clk) begin
        if (rx_valid_o) vcnt = vcnt + 1;
        if (rx_valid_o && !prev_v) rise_cyc = cyc;
        prev_v = rx_valid_o;
        if (frame_err_o)  fcnt = fcnt + 1;
        if (overrun_o)    ocnt = ocnt + 1;
        if (parity_err_o) pcnt = pcnt + 1;
    end

    int ncmp = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame, 16 ticks per cell; spike_bit selects a wire cell
    // (0 = start) whose centre tick is inverted. par_force < 0 sends the
    // correct even parity bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int par_force,
                              input int spike_bit, output int ts);
        logic [11:0] bits;
        int          n;
        bits    = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        n = 9;
`ifdef UART_RX_PARITY_EN
        bits[n] = (par_force < 0) ? ^d : par_force[0];
        n++;
`endif
        bits[n] = stop_v;
        n++;
        @(posedge sys_clk);
        #1;
        ts = cyc;
        for (int b = 0; b < n; b++) begin
            for (int t = 0; t < 16; t++) begin
                uart_rx_i = bits[b] ^ (b == spike_bit && t == 9);
                @(posedge sys_clk);
                #1;
            end
        end
        uart_rx_i = 1'b1;
    endtask

    int ts;
    int v0, f0, o0, p0;

    initial begin
        sys_rst_l  = 1'b0;
        uart_rx_i  = 1'b1;
        rx_ready_i = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_valid", 32'(rx_valid_o), 32'd0);
        check("rst_data", 32'(rx_data_o), 32'd0);
        check("rst_frame_err", 32'(frame_err_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_parity_err", 32'(parity_err_o), 32'd0);
        sys_rst_l = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;

        // Basic frame 0xA5
        v0 = vcnt; f0 = fcnt; o0 = ocnt; p0 = pcnt;
        send_frame(8'hA5, 1'b1, -1, -1, ts);
        check("a5_data", 32'(rx_data_o), 32'hA5);
        check("a5_valid_cycles", 32'(vcnt - v0), 32'd1);
        check("a5_latency", 32'(rise_cyc - ts), 32'(FRAME_LAT));
        check("a5_err_pulses", 32'((fcnt - f0) + (ocnt - o0) + (pcnt - p0)), 32'd0);

        // 4-tick glitch then 0x3C
        repeat (5) @(posedge sys_clk);
        #1;
        v0 = vcnt; f0 = fcnt; o0 = ocnt; p0 = pcnt;
        uart_rx_i = 1'b0;
        repeat (4) begin
            @(posedge sys_clk);
            #1;
        end
        uart_rx_i = 1'b1;
        repeat (40) @(posedge sys_clk);
        #1;
        check("glitch_valid", 32'(vcnt - v0), 32'd0);
        check("glitch_err_pulses", 32'((fcnt - f0) + (ocnt - o0) + (pcnt - p0)), 32'd0);
        send_frame(8'h3C, 1'b1, -1, -1, ts);
        check("3c_data", 32'(rx_data_o), 32'h3C);
        check("3c_valid_cycles", 32'(vcnt - v0), 32'd1);

        // Stop bit low, then line held low for 40 bit times
        repeat (5) @(posedge sys_clk);
        #1;
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h55, 1'b0, -1, -1, ts);
        uart_rx_i = 1'b0;
        repeat (640) @(posedge sys_clk);
        #1;
        check("brk_frame_err", 32'(fcnt - f0), 32'd1);
        check("brk_valid", 32'(vcnt - v0), 32'd0);
        uart_rx_i = 1'b1;
        repeat (40) @(posedge sys_clk);
        #1;
        send_frame(8'h12, 1'b1, -1, -1, ts);
        check("12_data", 32'(rx_data_o), 32'h12);
        check("12_valid_cycles", 32'(vcnt - v0), 32'd1);
        check("12_frame_err_total", 32'(fcnt - f0), 32'd1);

        // Overrun with consumer stalled
        repeat (5) @(posedge sys_clk);
        #1;
        rx_ready_i = 1'b0;
        o0 = ocnt;
        send_frame(8'h11, 1'b1, -1, -1, ts);
        check("ovr_first_valid", 32'(rx_valid_o), 32'd1);
        send_frame(8'h22, 1'b1, -1, -1, ts);
        check("ovr_valid_held", 32'(rx_valid_o), 32'd1);
        check("ovr_data_held", 32'(rx_data_o), 32'h11);
        check("ovr_pulses", 32'(ocnt - o0), 32'd1);
        rx_ready_i = 1'b1;
        @(posedge sys_clk);
        #1;
        check("ovr_accept_clears", 32'(rx_valid_o), 32'd0);

        // Spike on the centre sample of data bit 3 of 0xF0
        repeat (5) @(posedge sys_clk);
        #1;
        v0 = vcnt;
        send_frame(8'hF0, 1'b1, -1, 4, ts);
        check("spike_data", 32'(rx_data_o), 32'hF0);
        check("spike_valid_cycles", 32'(vcnt - v0), 32'd1);

        // Reset pulse during data bit 4 (remaining bits of 0xF1 are high)
        repeat (5) @(posedge sys_clk);
        #1;
        v0 = vcnt; f0 = fcnt; o0 = ocnt; p0 = pcnt;
        fork
            begin
                int ts_r;
                send_frame(8'hF1, 1'b1, -1, -1, ts_r);
            end
            begin
                repeat (86) @(posedge sys_clk);
                #3;
                sys_rst_l = 1'b0;
                #1;
                check("midrst_valid", 32'(rx_valid_o), 32'd0);
                check("midrst_data", 32'(rx_data_o), 32'd0);
                check("midrst_pulses", 32'({frame_err_o, overrun_o, parity_err_o}), 32'd0);
                @(posedge sys_clk);
                #3;
                sys_rst_l = 1'b1;
            end
        join
        repeat (20) @(posedge sys_clk);
        #1;
        check("midrst_no_output", 32'((vcnt - v0) + (fcnt - f0) + (ocnt - o0) + (pcnt - p0)), 32'd0);
        send_frame(8'h81, 1'b1, -1, -1, ts);
        check("81_data", 32'(rx_data_o), 32'h81);
        check("81_valid_cycles", 32'(vcnt - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, parity bit 1 is correct
        repeat (5) @(posedge sys_clk);
        #1;
        v0 = vcnt; p0 = pcnt;
        send_frame(8'h07, 1'b1, 1, -1, ts);
        check("par_ok_data", 32'(rx_data_o), 32'h07);
        check("par_ok_valid", 32'(vcnt - v0), 32'd1);
        check("par_ok_no_err", 32'(pcnt - p0), 32'd0);
        repeat (5) @(posedge sys_clk);
        #1;
        v0 = vcnt; p0 = pcnt;
        send_frame(8'h07, 1'b1, 0, -1, ts);
        check("par_bad_err", 32'(pcnt - p0), 32'd1);
        check("par_bad_no_valid", 32'(vcnt - v0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
